// File: rtl/core_wb_arbiter.sv
// Register-file write-back arbiter: tracks up to two outstanding loads, gives load
// returns priority over ALU results, and exposes stall/bypass. Optional bypass: CORE_WB_BYPASS_EN.
module core_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_wb,
   input  logic [3:0]  alu_rd,
   input  logic [31:0] alu_value,
   input  logic        ld_issue,
   input  logic [3:0]  ld_rd,
   input  logic        mem_ready,
   input  logic [31:0] mem_data,
   input  logic [3:0]  chk_ra,
   input  logic [3:0]  chk_rb,
   output logic        wr_en,
   output logic [3:0]  wr_rd,
   output logic [31:0] wr_value,
   output logic        stall,
   output logic        ld_pc,
   output logic        byp_a,
   output logic        byp_b,
   output logic [31:0] byp_value
);

   logic [1:0][3:0] fifo_q, fifo_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [15:0]     sb_q, sb_d;
   logic            skid_v_q, skid_v_d;
   logic [3:0]      skid_rd_q, skid_rd_d;
   logic [31:0]     skid_value_q, skid_value_d;
   logic            wr_en_q, wr_en_d;
   logic [3:0]      wr_rd_q, wr_rd_d;
   logic [31:0]     wr_value_q, wr_value_d;
   logic            ld_pc_q, ld_pc_d;

   logic            fifo_full;
   logic            pop;
   logic            push;
   logic [1:0]      slot;
   logic [3:0]      head;

   assign fifo_full = (cnt_q == 2'd2);
   assign head      = fifo_q[0];
   // A return with nothing outstanding is ignored entirely.
   assign pop       = mem_ready && (cnt_q != 2'd0);
   assign push      = ld_issue && (!fifo_full || pop);
   assign slot      = cnt_q - {1'b0, pop};

   // NOTE: every next-state signal gets a default first so no path can infer a latch.
   always_comb begin
      fifo_d       = fifo_q;
      cnt_d        = cnt_q + {1'b0, push} - {1'b0, pop};
      sb_d         = sb_q;
      skid_v_d     = skid_v_q;
      skid_rd_d    = skid_rd_q;
      skid_value_d = skid_value_q;
      wr_en_d      = 1'b0;
      wr_rd_d      = wr_rd_q;
      wr_value_d   = wr_value_q;
      ld_pc_d      = 1'b0;

      // Pop before push so a same-cycle pop/push of one register leaves its bit set.
      if (pop) begin
         fifo_d[0]  = fifo_q[1];
         sb_d[head] = 1'b0;
      end
      if (push) begin
         fifo_d[slot[0]] = ld_rd;
         sb_d[ld_rd]     = 1'b1;
      end

      if (pop) begin
         wr_en_d    = 1'b1;
         wr_rd_d    = head;
         wr_value_d = mem_data;
         ld_pc_d    = (head == 4'd15);
         if (alu_wb && !skid_v_q) begin
            skid_v_d     = 1'b1;
            skid_rd_d    = alu_rd;
            skid_value_d = alu_value;
         end
      end else if (skid_v_q) begin
         wr_en_d    = 1'b1;
         wr_rd_d    = skid_rd_q;
         wr_value_d = skid_value_q;
         skid_v_d   = 1'b0;
      end else if (alu_wb) begin
         wr_en_d    = 1'b1;
         wr_rd_d    = alu_rd;
         wr_value_d = alu_value;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_q       <= '0;
         cnt_q        <= '0;
         sb_q         <= '0;
         skid_v_q     <= 1'b0;
         skid_rd_q    <= '0;
         skid_value_q <= '0;
         wr_en_q      <= 1'b0;
         wr_rd_q      <= '0;
         wr_value_q   <= '0;
         ld_pc_q      <= 1'b0;
      end else begin
         fifo_q       <= fifo_d;
         cnt_q        <= cnt_d;
         sb_q         <= sb_d;
         skid_v_q     <= skid_v_d;
         skid_rd_q    <= skid_rd_d;
         skid_value_q <= skid_value_d;
         wr_en_q      <= wr_en_d;
         wr_rd_q      <= wr_rd_d;
         wr_value_q   <= wr_value_d;
         ld_pc_q      <= ld_pc_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_rd    = wr_rd_q;
   assign wr_value = wr_value_q;
   assign ld_pc    = ld_pc_q;

   assign stall = skid_v_q || sb_q[chk_ra] || sb_q[chk_rb] || sb_q[ld_rd] ||
                  (ld_issue && fifo_full && !mem_ready);

`ifdef CORE_WB_BYPASS_EN
   assign byp_a     = wr_en_q && (wr_rd_q == chk_ra);
   assign byp_b     = wr_en_q && (wr_rd_q == chk_rb);
   assign byp_value = wr_value_q;
`else
   assign byp_a     = 1'b0;
   assign byp_b     = 1'b0;
   assign byp_value = '0;
`endif

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter: expected writes are queued by the stimulus
// and a negedge monitor compares them against the write port.
module tb_core_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        alu_wb;
   logic [3:0]  alu_rd;
   logic [31:0] alu_value;
   logic        ld_issue;
   logic [3:0]  ld_rd;
   logic        mem_ready;
   logic [31:0] mem_data;
   logic [3:0]  chk_ra;
   logic [3:0]  chk_rb;
   logic        wr_en;
   logic [3:0]  wr_rd;
   logic [31:0] wr_value;
   logic        stall;
   logic        ld_pc;
   logic        byp_a;
   logic        byp_b;
   logic [31:0] byp_value;

   typedef struct {
      logic [3:0]  rd;
      logic [31:0] value;
      logic        pc;
   } wr_t;

   wr_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;

   core_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .alu_wb    (alu_wb),
      .alu_rd    (alu_rd),
      .alu_value (alu_value),
      .ld_issue  (ld_issue),
      .ld_rd     (ld_rd),
      .mem_ready (mem_ready),
      .mem_data  (mem_data),
      .chk_ra    (chk_ra),
      .chk_rb    (chk_rb),
      .wr_en     (wr_en),
      .wr_rd     (wr_rd),
      .wr_value  (wr_value),
      .stall     (stall),
      .ld_pc     (ld_pc),
      .byp_a     (byp_a),
      .byp_b     (byp_b),
      .byp_value (byp_value)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [3:0] rd, input logic [31:0] value, input logic pc);
      wr_t e;
      e.rd    = rd;
      e.value = value;
      e.pc    = pc;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      alu_wb    = 1'b0;
      alu_rd    = '0;
      alu_value = '0;
      ld_issue  = 1'b0;
      ld_rd     = '0;
      mem_ready = 1'b0;
      mem_data  = '0;
   endtask

   // Monitor: every write must match the next queued expectation; no write may appear unannounced.
   always @(negedge clk) begin
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got rd=%0d value=0x%08h, expected no write at %0t",
                     wr_rd, wr_value, $time);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_rd", {28'd0, wr_rd}, {28'd0, e.rd});
            check("wr_value", wr_value, e.value);
            check("ld_pc_on_write", {31'd0, ld_pc}, {31'd0, e.pc});
         end
      end else begin
         check("ld_pc_idle", {31'd0, ld_pc}, 32'd0);
      end
   end

   initial begin
      rst = 1'b1;
      idle();
      chk_ra = '0;
      chk_rb = '0;
      step();
      step();
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_wr_rd", {28'd0, wr_rd}, 32'd0);
      check("rst_wr_value", wr_value, 32'd0);
      check("rst_ld_pc", {31'd0, ld_pc}, 32'd0);
      check("rst_byp_a", {31'd0, byp_a}, 32'd0);
      check("rst_byp_b", {31'd0, byp_b}, 32'd0);
      check("rst_byp_value", byp_value, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      rst = 1'b0;
      step();

      // Plain ALU write, then the port holds its value while idle.
      alu_wb = 1'b1; alu_rd = 4'd3; alu_value = 32'h1234_5678;
      expect_wr(4'd3, 32'h1234_5678, 1'b0);
      #1 check("alu_stall", {31'd0, stall}, 32'd0);
      step();
      idle();
      step();
      check("hold_wr_en", {31'd0, wr_en}, 32'd0);
      check("hold_wr_rd", {28'd0, wr_rd}, 32'd3);
      check("hold_wr_value", wr_value, 32'h1234_5678);

      // Load-use hazard on r5.
      ld_issue = 1'b1; ld_rd = 4'd5;
      step();
      idle();
      chk_ra = 4'd5;
      #1 check("hazard_stall_0", {31'd0, stall}, 32'd1);
      step();
      check("hazard_stall_1", {31'd0, stall}, 32'd1);
      mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF;
      expect_wr(4'd5, 32'hDEAD_BEEF, 1'b0);
      #1 check("hazard_stall_ret", {31'd0, stall}, 32'd1);
      step();
      idle();
      #1 check("hazard_released", {31'd0, stall}, 32'd0);
      chk_ra = '0;
      step();

      // Load return collides with ALU write: ALU goes through the skid buffer.
      ld_issue = 1'b1; ld_rd = 4'd6;
      step();
      idle();
      mem_ready = 1'b1; mem_data = 32'h600D_F00D;
      alu_wb = 1'b1; alu_rd = 4'd2; alu_value = 32'h0000_00AA;
      expect_wr(4'd6, 32'h600D_F00D, 1'b0);
      expect_wr(4'd2, 32'h0000_00AA, 1'b0);
      step();
      idle();
      #1 check("skid_stall", {31'd0, stall}, 32'd1);
      step();
      #1 check("skid_drained", {31'd0, stall}, 32'd0);

      // FIFO full: third load stalls, then is accepted alongside a return.
      ld_issue = 1'b1; ld_rd = 4'd1;
      step();
      ld_rd = 4'd4;
      step();
      ld_rd = 4'd8;
      #1 check("full_stall", {31'd0, stall}, 32'd1);
      step();
      mem_ready = 1'b1; mem_data = 32'h1111_1111;
      expect_wr(4'd1, 32'h1111_1111, 1'b0);
      #1 check("full_pop_push_stall", {31'd0, stall}, 32'd0);
      step();
      idle();
      mem_ready = 1'b1; mem_data = 32'h4444_4444;
      expect_wr(4'd4, 32'h4444_4444, 1'b0);
      step();
      mem_data = 32'h8888_8888;
      expect_wr(4'd8, 32'h8888_8888, 1'b0);
      step();
      mem_data = 32'h0000_0BAD;
      step();
      idle();
      step();

      // Same register popped and pushed together keeps its scoreboard bit.
      ld_issue = 1'b1; ld_rd = 4'd9;
      step();
      mem_ready = 1'b1; mem_data = 32'h0000_0099;
      expect_wr(4'd9, 32'h0000_0099, 1'b0);
      step();
      idle();
      chk_ra = 4'd9;
      #1 check("same_rd_still_set", {31'd0, stall}, 32'd1);
      mem_ready = 1'b1; mem_data = 32'h0000_009A;
      expect_wr(4'd9, 32'h0000_009A, 1'b0);
      step();
      idle();
      #1 check("same_rd_cleared", {31'd0, stall}, 32'd0);
      chk_ra = '0;

      // Load into r15 raises ld_pc with its write.
      ld_issue = 1'b1; ld_rd = 4'd15;
      step();
      idle();
      mem_ready = 1'b1; mem_data = 32'hCAFE_0000;
      expect_wr(4'd15, 32'hCAFE_0000, 1'b1);
      step();
      idle();
      step();

      // Reset with two loads in flight discards them.
      ld_issue = 1'b1; ld_rd = 4'd10;
      step();
      ld_rd = 4'd11;
      step();
      idle();
      chk_ra = 4'd10;
      #1 check("pre_rst_stall", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("mid_rst_wr_rd", {28'd0, wr_rd}, 32'd0);
      check("mid_rst_wr_value", wr_value, 32'd0);
      check("mid_rst_stall", {31'd0, stall}, 32'd0);
      step();
      rst = 1'b0;
      step();
      mem_ready = 1'b1; mem_data = 32'h0000_0BAD;
      step();
      idle();
      check("post_rst_stall", {31'd0, stall}, 32'd0);
      chk_ra = '0;
      step();
      step();

      // Bypass against the registered write port.
      alu_wb = 1'b1; alu_rd = 4'd7; alu_value = 32'h0000_0077;
      expect_wr(4'd7, 32'h0000_0077, 1'b0);
      step();
      idle();
      chk_rb = 4'd7;
      chk_ra = 4'd3;
      #1;
`ifdef CORE_WB_BYPASS_EN
      check("byp_b", {31'd0, byp_b}, 32'd1);
      check("byp_value", byp_value, 32'h0000_0077);
`else
      check("byp_b", {31'd0, byp_b}, 32'd0);
      check("byp_value", byp_value, 32'd0);
`endif
      check("byp_a", {31'd0, byp_a}, 32'd0);
      check("byp_stall", {31'd0, stall}, 32'd0);
      chk_ra = '0;
      chk_rb = '0;
      step();
      step();

      check("pending_writes", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/core_wb_arbiter.md
CORE_WB_ARBITER -- requirements
Module: core_wb_arbiter

Interface
REQ-001 SHALL provide: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL provide: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: alu_wb  in  1  ALU result write request this cycle.
REQ-004 SHALL provide: alu_rd  in  4  ALU destination register number.
REQ-005 SHALL provide: alu_value  in  32  ALU result word.
REQ-006 SHALL provide: ld_issue  in  1  load issued, destination to be tracked.
REQ-007 SHALL provide: ld_rd  in  4  load destination register number.
REQ-008 SHALL provide: mem_ready  in  1  load data returning this cycle; cannot be back-pressured.
REQ-009 SHALL provide: mem_data  in  32  returned load word.
REQ-010 SHALL provide: chk_ra, chk_rb  in  4 each  operand registers of the instruction in decode.
REQ-011 SHALL provide: wr_en  out  1, wr_rd  out  4, wr_value  out  32  register-file write port.
REQ-012 SHALL provide: stall  out  1  decode must hold.
REQ-013 SHALL provide: ld_pc  out  1  pulse, committed load targeted r15.
REQ-014 SHALL provide: byp_a, byp_b  out  1 each; byp_value  out  32  operand bypass.

Function
REQ-015 SHALL keep a 2-entry pending-load FIFO of 4-bit register numbers: push on ld_issue, pop on mem_ready.
REQ-016 SHALL keep a 16-bit scoreboard: bit set on push, cleared on pop for that register.
REQ-017 SHALL register the write port: request in cycle N gives wr_en/wr_rd/wr_value in cycle N+1.
REQ-018 SHALL give a load response priority; a colliding alu_wb is captured in a 1-entry skid buffer and written in the first cycle with no mem_ready.
REQ-019 SHALL assert stall combinationally when any of these holds: skid buffer occupied; scoreboard bit set for chk_ra, chk_rb or ld_rd; ld_issue with FIFO full and no simultaneous mem_ready.
REQ-020 SHALL, on simultaneous push and pop with the FIFO full, pop then push; count stays 2.
REQ-021 SHALL, on simultaneous push and pop of the same register, leave that scoreboard bit set.
REQ-022 SHALL ignore mem_ready when the FIFO is empty: no write, no state change.
REQ-023 SHALL drain the skid buffer before a new alu_wb; with the skid buffer occupied, an alu_wb from upstream is a protocol violation with undefined behaviour.
REQ-024 SHALL pulse ld_pc one cycle, coincident with wr_en, when a load commits to register 15.
REQ-025 SHALL leave wr_rd/wr_value unchanged when wr_en is 0.

Reset
REQ-026 SHALL on rst clear FIFO, scoreboard and skid buffer; wr_en=0, wr_rd=0, wr_value=0, ld_pc=0, byp_a=byp_b=0, byp_value=0; stall=0.
REQ-027 SHALL discard in-flight loads on a reset asserted mid-operation; later mem_ready is ignored per REQ-022.

Configuration
REQ-028 SHALL honour macro CORE_WB_BYPASS_EN; when defined, byp_a/byp_b=wr_en and wr_rd equals chk_ra/chk_rb, and byp_value=wr_value.
REQ-029 SHALL, without CORE_WB_BYPASS_EN, tie byp_a, byp_b and byp_value to 0; stall is identical in both builds.

Verification
REQ-030 SHALL cover: alu_wb=1, alu_rd=3, alu_value=0x12345678 -> next cycle wr_en=1, wr_rd=3, wr_value=0x12345678, stall=0.
REQ-031 SHALL cover: ld_issue ld_rd=5, then chk_ra=5 -> stall=1 until mem_ready with mem_data=0xDEADBEEF; next cycle wr_rd=5 and stall drops.
REQ-032 SHALL cover: mem_ready and alu_wb (rd=2, 0xAA) in same cycle -> load written first, stall=1 one cycle, rd=2 value 0xAA written the following cycle.
REQ-033 SHALL cover: two loads issued (rd 1, 4), third ld_issue -> stall=1; third issued with mem_ready -> accepted, FIFO returns 4 then new rd in order.
REQ-034 SHALL cover: load to r15 committing -> ld_pc=1 exactly one cycle; rst mid-flight with 2 loads pending -> all outputs 0, next mem_ready causes no write.
REQ-035 SHALL cover with CORE_WB_BYPASS_EN: wr_en=1, wr_rd=7, chk_rb=7 -> byp_b=1, byp_value=wr_value; without macro byp_b=0.
